// File: rtl/uart_sys_ctrl.sv
// uart_sys_ctrl
//   Debug command controller between the host UART and the NES CPU-side bus.
//   Parses host commands (write 02 hi lo data, read 03 hi lo, CPU reset 06,
//   CPU release 07), masters the shared bus through a req/gnt/ack handshake,
//   holds the 6502 in reset on command and returns read data to the UART TX.
//
// Ports
//   clk, rst                 : system clock, asynchronous active-low reset
//   rx_valid, rx_data        : received byte strobe and data
//   tx_start, tx_data        : transmit request pulse and byte (held until TX done)
//   tx_active                : transmitter busy
//   bus_req, bus_gnt         : bus request / grant
//   bus_addr, bus_wdata      : access address and write data
//   bus_we, bus_re           : write / read strobes, held until bus_ack
//   bus_ack, bus_rdata       : access-complete strobe and read data
//   cpu_rst_n                : 0 holds the 6502 in reset
//   sys_addr                 : last fully parsed address
//   cmd_abort                : one-cycle pulse when an inter-byte gap times out
//   drop_cnt                 : saturating count of bytes dropped while busy
module uart_sys_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_rst_n,
    output logic [15:0] sys_addr,
    output logic        cmd_abort,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_CPU_RST = 8'h06;
    localparam logic [7:0] OP_CPU_REL = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_HI  = 3'd1,
        ST_ADDR_LO  = 3'd2,
        ST_DATA     = 3'd3,
        ST_REQ      = 3'd4,
        ST_ACCESS   = 3'd5,
        ST_TX_START = 3'd6,
        ST_TX_WAIT  = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             is_write_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic             txw_first_r;
    logic             counting_s;
    logic             timeout_s;
    logic             tx_go_s;
    logic             abort_s;
    logic             drop_s;

    logic             tx_start_r;
    logic [7:0]       tx_data_r;
    logic             bus_req_r;
    logic [15:0]      bus_addr_r;
    logic [7:0]       bus_wdata_r;
    logic             bus_we_r;
    logic             bus_re_r;
    logic             cpu_rst_n_r;
    logic [15:0]      sys_addr_r;
    logic             cmd_abort_r;
    logic [7:0]       drop_cnt_r;

    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign bus_req   = bus_req_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_we    = bus_we_r;
    assign bus_re    = bus_re_r;
    assign cpu_rst_n = cpu_rst_n_r;
    assign sys_addr  = sys_addr_r;
    assign cmd_abort = cmd_abort_r;
    assign drop_cnt  = drop_cnt_r;

    // The gap timer only runs while a command is partially received.
    assign counting_s = (state_r == ST_ADDR_HI) || (state_r == ST_ADDR_LO) || (state_r == ST_DATA);
    assign timeout_s  = counting_s && (gap_cnt_r == GAP_LAST);

    // Next-state decode plus the per-cycle transmit, abort and drop requests
    always_comb begin
        state_nxt_s = state_r;
        tx_go_s     = 1'b0;
        abort_s     = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && ((rx_data == OP_WRITE) || (rx_data == OP_READ))) begin
                    state_nxt_s = ST_ADDR_HI;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR_HI, ST_ADDR_LO, ST_DATA: begin
                // A byte arriving on the timeout cycle wins over the abort.
                if (rx_valid) begin
                    if (state_r == ST_ADDR_HI) begin
                        state_nxt_s = ST_ADDR_LO;
                    end else if ((state_r == ST_ADDR_LO) && is_write_r) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_REQ: begin
                drop_s = rx_valid;
                if (bus_gnt) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_ACCESS: begin
                drop_s = rx_valid;
                if (bus_ack && is_write_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus_ack) begin
                    // Launch the reply immediately when the transmitter is idle.
                    state_nxt_s = ST_TX_START;
                    tx_go_s     = !tx_active;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_TX_START: begin
                drop_s = rx_valid;
                if (tx_start_r) begin
                    state_nxt_s = ST_TX_WAIT;
                end else begin
                    state_nxt_s = ST_TX_START;
                    tx_go_s     = !tx_active;
                end
            end
            ST_TX_WAIT: begin
                drop_s = rx_valid;
                // First cycle is skipped so tx_active has time to rise.
                if (!txw_first_r && !tx_active) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_TX_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and first-cycle-of-TX_WAIT marker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            txw_first_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            txw_first_r <= (state_nxt_s == ST_TX_WAIT) && (state_r != ST_TX_WAIT);
        end
    end

    // Command parsing: opcode, address, write data, CPU reset control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_write_r  <= 1'b0;
            bus_addr_r  <= 16'h0000;
            bus_wdata_r <= 8'h00;
            sys_addr_r  <= 16'h0000;
            cpu_rst_n_r <= 1'b1;
        end else if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        is_write_r <= (rx_data == OP_WRITE);
                    end
                    if (rx_data == OP_CPU_RST) begin
                        cpu_rst_n_r <= 1'b0;
                    end else if (rx_data == OP_CPU_REL) begin
                        cpu_rst_n_r <= 1'b1;
                    end
                end
                ST_ADDR_HI: bus_addr_r[15:8] <= rx_data;
                ST_ADDR_LO: begin
                    bus_addr_r[7:0] <= rx_data;
                    sys_addr_r      <= {bus_addr_r[15:8], rx_data};
                end
                ST_DATA:    bus_wdata_r <= rx_data;
                default:    bus_wdata_r <= bus_wdata_r;
            endcase
        end
    end

    // Inter-byte gap timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt_r <= '0;
        end else if (!counting_s || rx_valid || timeout_s) begin
            gap_cnt_r <= '0;
        end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
        end
    end

    // Registered bus/UART strobes, read-data capture and drop counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_re_r    <= 1'b0;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            cmd_abort_r <= 1'b0;
            drop_cnt_r  <= 8'h00;
        end else begin
            bus_req_r   <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_ACCESS);
            bus_we_r    <= (state_nxt_s == ST_ACCESS) && is_write_r;
            bus_re_r    <= (state_nxt_s == ST_ACCESS) && !is_write_r;
            tx_start_r  <= tx_go_s;
            cmd_abort_r <= abort_s;
            if ((state_r == ST_ACCESS) && bus_ack && !is_write_r) begin
                tx_data_r <= bus_rdata;
            end
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// tb_uart_sys_ctrl: scoreboard bench for uart_sys_ctrl with a bus
// arbiter/memory model and a UART transmitter model.
module tb_uart_sys_ctrl;

    localparam int TO = 40;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        cpu_rst_n;
    logic [15:0] sys_addr;
    logic        cmd_abort;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_txn_t;

    bus_txn_t   exp_bus[$];
    logic [7:0] exp_tx[$];

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_delay = 2;
    int ack_delay = 1;
    int uart_len  = 8;
    bit hold_ack  = 1'b0;
    int abort_cnt = 0;
    int req_cnt   = 0;

    uart_sys_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .cpu_rst_n (cpu_rst_n),
        .sys_addr  (sys_addr),
        .cmd_abort (cmd_abort),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_bus(input logic we, input logic [15:0] addr, input logic [7:0] data);
        bus_txn_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        exp_bus.push_back(t);
        if (!we) exp_tx.push_back(data);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((n < 2000) && ((exp_bus.size() != 0) || (exp_tx.size() != 0) ||
               bus_req || tx_active || tx_start)) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_done"}, (n < 2000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Event counters sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_abort) abort_cnt++;
            if (bus_req) req_cnt++;
        end
    end

    // Bus arbiter + memory model: grants, acks, checks accesses against the scoreboard
    initial begin
        int       gnt_cnt;
        int       ack_cnt;
        bit       gnt_new;
        bit       rd_turn_pend;
        bus_txn_t e;
        gnt_cnt = 0; ack_cnt = 0; gnt_new = 1'b0; rd_turn_pend = 1'b0;
        bus_gnt = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (rd_turn_pend) begin
                rd_turn_pend = 1'b0;
                check_val("rd_turnaround_tx_start", tx_start, 1);
            end
            if (!bus_req) begin
                bus_gnt = 1'b0; gnt_cnt = 0; ack_cnt = 0; gnt_new = 1'b0;
            end else if (!bus_gnt) begin
                if (gnt_cnt >= gnt_delay) begin
                    bus_gnt = 1'b1;
                    gnt_new = 1'b1;
                end else begin
                    gnt_cnt++;
                end
            end else begin
                if (gnt_new) begin
                    gnt_new = 1'b0;
                    check_val("strobe_after_gnt", (bus_we || bus_re), 1);
                end
                if (!hold_ack && (bus_we || bus_re)) begin
                    if (ack_cnt >= ack_delay) begin
                        check_val("sb_bus_nonempty", (exp_bus.size() != 0), 1);
                        if (exp_bus.size() != 0) begin
                            e = exp_bus.pop_front();
                            check_val("bus_we", bus_we, e.we);
                            check_val("bus_re", bus_re, !e.we);
                            check_val("bus_addr", bus_addr, e.addr);
                            if (e.we) begin
                                check_val("bus_wdata", bus_wdata, e.data);
                            end else begin
                                bus_rdata    = e.data;
                                rd_turn_pend = 1'b1;
                            end
                        end
                        bus_ack = 1'b1;
                        ack_cnt = 0;
                    end else begin
                        ack_cnt++;
                    end
                end
            end
        end
    end

    // UART transmitter model: captures each started byte and stays busy uart_len cycles
    initial begin
        int busy_cnt;
        logic [7:0] eb;
        busy_cnt  = 0;
        tx_active = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_active = 1'b0;
            end
            if (tx_start) begin
                check_val("sb_tx_nonempty", (exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0) begin
                    eb = exp_tx.pop_front();
                    check_val("tx_data", tx_data, eb);
                end
                tx_active = 1'b1;
                busy_cnt  = uart_len;
            end
        end
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        int a0;
        int r0;
        int k;
        int n;
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check_val("rst_strobes", {tx_start, bus_req, bus_we, bus_re, cmd_abort}, 5'b0);
        check_val("rst_tx_data", tx_data, 8'h00);
        check_val("rst_bus_addr", bus_addr, 16'h0000);
        check_val("rst_bus_wdata", bus_wdata, 8'h00);
        check_val("rst_sys_addr", sys_addr, 16'h0000);
        check_val("rst_drop_cnt", drop_cnt, 8'h00);
        check_val("rst_cpu_rst_n", cpu_rst_n, 1);

        // CPU control
        r0 = req_cnt;
        send_byte(8'h06);
        check_val("cpu_hold", cpu_rst_n, 0);
        send_byte(8'h55);
        check_val("cpu_stray_hold", cpu_rst_n, 0);
        send_byte(8'h07);
        check_val("cpu_release", cpu_rst_n, 1);
        send_byte(8'h55);
        check_val("cpu_stray_rel", cpu_rst_n, 1);
        check_val("cpu_no_req", req_cnt - r0, 0);

        // Write path
        gnt_delay = 3; ack_delay = 2;
        push_bus(1'b1, 16'h8000, 8'hA9);
        send_byte(8'h02); send_byte(8'h80); send_byte(8'h00); send_byte(8'hA9);
        check_val("wr_req_rise", bus_req, 1);
        check_val("wr_sys_addr", sys_addr, 16'h8000);
        wait_done("wr");

        // Read path
        gnt_delay = 2; ack_delay = 1;
        push_bus(1'b0, 16'h3F00, 8'h0F);
        send_byte(8'h03); send_byte(8'h3F); send_byte(8'h00);
        check_val("rd_req_rise", bus_req, 1);
        wait_done("rd");
        check_val("rd_sys_addr", sys_addr, 16'h3F00);

        // Minimum access: immediate grant and ack in the first ACCESS cycle
        gnt_delay = 0; ack_delay = 0;
        push_bus(1'b1, 16'h1234, 8'h56);
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        wait_done("wr_min");

        // Timeout after addr_hi: one abort TO cycles after the last byte, no access
        a0 = abort_cnt; r0 = req_cnt; k = 0;
        send_byte(8'h02); send_byte(8'h12);
        for (int i = 1; i <= TO + 20; i++) begin
            @(posedge clk); #1;
            if (cmd_abort && (k == 0)) k = i;
        end
        check_val("to_abort_cycle", k, TO);
        check_val("to_abort_count", abort_cnt - a0, 1);
        check_val("to_no_req", req_cnt - r0, 0);
        check_val("to_sys_addr_kept", sys_addr, 16'h1234);
        gnt_delay = 1; ack_delay = 1;
        push_bus(1'b0, 16'h0010, 8'h5A);
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h10);
        wait_done("to_rd");

        // Timeout after addr_lo completed: sys_addr already updated
        a0 = abort_cnt;
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        repeat (TO + 5) @(posedge clk);
        #1;
        check_val("to_lo_abort", abort_cnt - a0, 1);
        check_val("to_lo_sys_addr", sys_addr, 16'hAABB);

        // Byte arriving on the timeout cycle wins
        a0 = abort_cnt;
        push_bus(1'b1, 16'h7788, 8'h99);
        send_byte(8'h02); send_byte(8'h77);
        repeat (TO - 2) @(posedge clk);
        send_byte(8'h88); send_byte(8'h99);
        wait_done("to_edge");
        check_val("to_edge_no_abort", abort_cnt - a0, 0);

        // Overrun: 3 bytes dropped during TX_WAIT
        uart_len = 60;
        push_bus(1'b0, 16'h4000, 8'h3C);
        send_byte(8'h03); send_byte(8'h40); send_byte(8'h00);
        n = 0;
        while (!tx_active && (n < 200)) begin @(posedge clk); #1; n++; end
        check_val("ovr_tx_busy", tx_active, 1);
        send_byte(8'h02); send_byte(8'h06); send_byte(8'h03);
        check_val("ovr_drop3", drop_cnt, 8'd3);
        check_val("ovr_cpu_kept", cpu_rst_n, 1);
        wait_done("ovr3");
        check_val("ovr_drop3_after", drop_cnt, 8'd3);

        // Overrun saturation: 300 more bytes
        uart_len = 400;
        push_bus(1'b0, 16'h4001, 8'hC3);
        send_byte(8'h03); send_byte(8'h40); send_byte(8'h01);
        n = 0;
        while (!tx_active && (n < 200)) begin @(posedge clk); #1; n++; end
        check_val("sat_tx_busy", tx_active, 1);
        for (int i = 0; i < 300; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check_val("sat_drop", drop_cnt, 8'd255);
        check_val("sat_cpu_kept", cpu_rst_n, 1);
        wait_done("sat");
        uart_len = 8;

        // Reset in the middle of a write access
        send_byte(8'h06);
        check_val("mid_cpu_hold", cpu_rst_n, 0);
        hold_ack = 1'b1; gnt_delay = 1;
        send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        n = 0;
        while (!bus_we && (n < 100)) begin @(posedge clk); #1; n++; end
        check_val("mid_we_seen", bus_we, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_strobes", {tx_start, bus_req, bus_we, bus_re, cmd_abort}, 5'b0);
        check_val("mid_cpu_rst_n", cpu_rst_n, 1);
        check_val("mid_addr", bus_addr, 16'h0000);
        check_val("mid_drop", drop_cnt, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hold_ack = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_req", bus_req, 0);
        check_val("post_rst_sys_addr", sys_addr, 16'h0000);
        push_bus(1'b0, 16'h1234, 8'hE7);
        send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
        wait_done("post_rst_rd");

        check_val("sb_bus_empty", exp_bus.size(), 0);
        check_val("sb_tx_empty", exp_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
